uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Shares the board UART between two byte producers: 0 = CPU MMIO store path, 1 = debug monitor.
//  - TX: round-robin arbiter; paces each frame by timer, since the UART exposes no busy flag.
//  - RX: turns the UART's multi-cycle done level into a one-deep, acked holding register
//    with overrun detect.
//  - Sits between the bus/debug logic and the UART instance, in the same clk domain.
// PARAMETERS
//  CLK_FREQ   50000000  system clock, Hz
//  UART_BPS   115200    baud; BPS_CNT = CLK_FREQ/UART_BPS (434 at defaults)
//  PULSE_CYC  4         cycles uart_send_en is held high per byte (>=3; UART syncs it through 2 flops)
//  GUARD_CYC  8         idle cycles added after each frame; FRAME_CYC = 10*BPS_CNT + GUARD_CYC
// PORTS
//  clk           in   1  system clock, rising edge
//  resetn        in   1  reset, asynchronous, active-low
//  req0_valid    in   1  CPU has a byte to send
//  req0_data     in   8  CPU byte
//  req0_ready    out  1  CPU byte accepted this cycle when valid&ready
//  req1_valid    in   1  debug has a byte to send
//  req1_data     in   8  debug byte
//  req1_ready    out  1  debug byte accepted this cycle when valid&ready
//  uart_send_en  out  1  to UART send enable (level pulse)
//  uart_din      out  8  to UART tx byte
//  tx_busy       out  1  1 whenever state != IDLE
//  rx_done_i     in   1  UART uart_done (level, several cycles long)
//  rx_byte_i     in   8  UART uart_data (valid while rx_done_i=1)
//  rx_valid      out  1  rx_data holds an unread byte
//  rx_data       out  8  received byte
//  rx_ack        in   1  consumer read pulse; clears rx_valid
//  rx_overrun    out  1  sticky: a byte was dropped
//  rx_overrun_clr in  1  clears rx_overrun
// BEHAVIOUR
//  Reset values (async on resetn=0)
//  - uart_send_en=0, uart_din=0, rx_valid=0, rx_data=0, rx_overrun=0, timer=0, last_grant=1.
//  - State = WAIT, so tx_busy=1: a frame in flight in the UART (separate reset) is never
//    clobbered after reset release.
//  TX FSM
//  - IDLE:
//    - Grant rule: one valid -> it wins; both valid -> requester != last_grant.
//    - reqN_ready=1 combinationally only for the granted requester; 0 in every other state.
//    - Accept (valid&ready) at cycle T: latch uart_din<=data, last_grant<=N, timer<=0, -> PULSE.
//  - PULSE:
//    - uart_send_en=1 from T+1 through T+PULSE_CYC; timer increments each cycle.
//    - At timer==PULSE_CYC-1 -> WAIT.
//  - WAIT:
//    - uart_send_en=0; timer increments.
//    - At timer==FRAME_CYC-1 -> IDLE; IDLE first seen at T+FRAME_CYC+1.
//  Arithmetic and hold rules
//  - uart_din holds its value until the next accept; never changes during PULSE/WAIT.
//  - Requester valid dropping during PULSE/WAIT has no effect; ungranted valid simply waits.
//  - Back-to-back accepts are spaced exactly FRAME_CYC+1 cycles.
//  - timer is 16 bits; FRAME_CYC must be < 65536 (elaboration check).
//  RX path
//  - done_d <= rx_done_i; capture strobe = rx_done_i & ~done_d (one strobe per frame).
//  - Strobe with rx_valid=0, or with rx_ack same cycle: rx_data<=rx_byte_i, rx_valid<=1.
//  - Strobe with rx_valid=1 and no rx_ack: byte dropped, rx_data kept, rx_overrun<=1.
//  - rx_ack without strobe: rx_valid<=0; rx_data unchanged.
//  - rx_overrun set and rx_overrun_clr in the same cycle: set wins.
// STRUCTURE
//  - Package uart_ctrl_pkg:
//    - State encoding localparams (IDLE=2'd0, PULSE=2'd1, WAIT=2'd2).
//    - BPS_CNT/FRAME_CYC computation, shared with the UART instance parameters.
//  - Sub-module rr_arb2: 2-way round-robin grant from valids + last_grant.
//  - Timer, FSM and RX holding logic stay inline.
// TESTING  (CLK_FREQ=1000, UART_BPS=100 -> BPS_CNT=10, PULSE_CYC=4, GUARD_CYC=8, FRAME_CYC=108)
//  1. Reset release, req0_valid=1 data 8'h55 from cycle 0
//     -> no ready until 108 cycles after reset release; then accept;
//     -> uart_send_en high 4 cycles; uart_din=8'h55 stable for 108 cycles.
//  2. Both valid continuously (req0=8'hA1, req1=8'hB2)
//     -> grants alternate 1st=req0, 2nd=req1, 3rd=req0; accepts exactly 109 cycles apart.
//  3. UART loopback (txd->rxd), send 8'h3C via req1
//     -> rx_valid rises once with rx_data=8'h3C; a single rx_done_i level yields one capture.
//  4. Two frames received, no rx_ack
//     -> rx_data=first byte, rx_overrun=1; overrun_clr and a new-byte strobe in the same cycle
//     -> rx_overrun stays 1.
//  5. rx_ack coincident with a new strobe
//     -> rx_data=new byte, rx_valid=1, rx_overrun=0.
//  6. resetn pulsed low during PULSE
//     -> uart_send_en=0 immediately (async); after release tx_busy=1 for 108 cycles before any ready.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and frame-timing helpers for the UART TX scheduler and the UART instance.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } tx_state_t;

    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // One start, eight data and one stop bit, plus an idle guard gap.
    function automatic int frame_cyc(input int bps, input int guard_cyc);
        return 10 * bps + guard_cyc;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention the one not served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART between CPU (0) and debug (1) senders with timer-paced frames, and
// converts the UART's receive-done level into an acked one-deep holding register.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int PULSE_CYC = 4,
    parameter int GUARD_CYC = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       uart_send_en,
    output logic [7:0] uart_din,
    output logic       tx_busy,
    input  logic       rx_done_i,
    input  logic [7:0] rx_byte_i,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ack,
    output logic       rx_overrun,
    input  logic       rx_overrun_clr
);

    localparam int BPS_CNT   = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int FRAME_CYC = frame_cyc(BPS_CNT, GUARD_CYC);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYC - 1);

    if (FRAME_CYC >= 65536 || PULSE_CYC < 3 || PULSE_CYC >= FRAME_CYC) begin : g_bad_cfg
        $error("uart_tx_sched: FRAME_CYC must be < 65536 and PULSE_CYC in [3, FRAME_CYC)");
    end

    tx_state_t   state;
    logic [15:0] timer;
    logic        last_grant;
    logic [1:0]  grant;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = grant[0] & (state == IDLE);
    assign req1_ready = grant[1] & (state == IDLE);
    assign tx_busy    = (state != IDLE);

    // Reset lands in WAIT so a frame the UART may still be shifting out is allowed to finish.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= WAIT;
            timer        <= '0;
            uart_send_en <= 1'b0;
            uart_din     <= '0;
            last_grant   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        uart_din     <= grant[1] ? req1_data : req0_data;
                        last_grant   <= grant[1];
                        timer        <= '0;
                        uart_send_en <= 1'b1;
                        state        <= PULSE;
                    end
                end
                PULSE: begin
                    timer <= timer + 16'd1;
                    if (timer == PULSE_LAST) begin
                        uart_send_en <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + 16'd1;
                    if (timer == FRAME_LAST) state <= IDLE;
                end
                default: begin
                    uart_send_en <= 1'b0;
                    timer        <= '0;
                    state        <= WAIT;
                end
            endcase
        end
    end

    logic done_d;
    logic strobe;
    logic drop;

    assign strobe = rx_done_i & ~done_d;
    assign drop   = strobe & rx_valid & ~rx_ack;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_d     <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            done_d <= rx_done_i;
            if (strobe && !drop) begin
                rx_data  <= rx_byte_i;
                rx_valid <= 1'b1;
            end else if (!strobe && rx_ack) begin
                rx_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                rx_overrun <= 1'b1;
            else if (rx_overrun_clr)
                rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed sequences, an RX vector table and random traffic
// checked every cycle against a frame-budget reference model.
module tb_uart_tx_sched;

    localparam int CF = 1000, BPS = 100, PC = 4, GC = 8;
    localparam int FC = 10 * (CF / BPS) + GC;  // 108

    logic       clk = 1'b0, resetn = 1'b0;
    logic       req0_valid = 0, req1_valid = 0, rx_done_i = 0, rx_ack = 0, rx_overrun_clr = 0;
    logic [7:0] req0_data = 0, req1_data = 0, rx_byte_i = 0;
    logic       req0_ready, req1_ready, uart_send_en, tx_busy, rx_valid, rx_overrun;
    logic [7:0] uart_din, rx_data;

    uart_tx_sched #(.CLK_FREQ(CF), .UART_BPS(BPS), .PULSE_CYC(PC), .GUARD_CYC(GC)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .uart_send_en(uart_send_en), .uart_din(uart_din), .tx_busy(tx_busy),
        .rx_done_i(rx_done_i), .rx_byte_i(rx_byte_i),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
        .rx_overrun(rx_overrun), .rx_overrun_clr(rx_overrun_clr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: cycles of busy time left, send pulse cycles left, and the RX register.
    int         busy_left, pulse_left, m_last, cyc;
    logic [7:0] m_din, m_rxd;
    logic       m_rxv, m_ovr, m_done_prev;
    int         acc_cyc[$];
    int         acc_who[$];

    typedef struct {
        logic       done;
        logic [7:0] byt;
        logic       ack;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_ovr;
    } rx_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic init_model();
        busy_left = FC; pulse_left = 0; m_last = 1; m_din = 8'h00;
        m_rxv = 0; m_rxd = 8'h00; m_ovr = 0; m_done_prev = 0;
        cyc = 0; acc_cyc.delete(); acc_who.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        init_model();
        resetn = 1'b1;
    endtask

    // Inputs for this cycle are already driven; check, then advance the model over the next edge.
    task automatic step();
        int g;
        logic strobe, drop;
        #1;
        g = -1;
        if (busy_left == 0) begin
            if (req0_valid && (!req1_valid || m_last == 1)) g = 0;
            else if (req1_valid) g = 1;
        end
        chk("tx_busy", tx_busy, busy_left > 0);
        chk("send_en", uart_send_en, pulse_left > 0);
        chk("uart_din", uart_din, m_din);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("rx_valid", rx_valid, m_rxv);
        chk("rx_data", rx_data, m_rxd);
        chk("rx_overrun", rx_overrun, m_ovr);
        if (busy_left > 0) busy_left--;
        if (pulse_left > 0) pulse_left--;
        if (g >= 0) begin
            busy_left = FC;
            pulse_left = PC;
            m_last = g;
            m_din = (g == 1) ? req1_data : req0_data;
            acc_cyc.push_back(cyc);
            acc_who.push_back(g);
        end
        strobe = rx_done_i && !m_done_prev;
        m_done_prev = rx_done_i;
        drop = strobe && m_rxv && !rx_ack;
        if (strobe && !drop) begin m_rxd = rx_byte_i; m_rxv = 1; end
        else if (!strobe && rx_ack) m_rxv = 0;
        if (drop) m_ovr = 1;
        else if (rx_overrun_clr) m_ovr = 0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rx_vec_t vt[$];
        int hi, rises, lb_at, done_left;
        logic prev_v;

        // Reset state, with a requester already pending.
        init_model();
        req0_valid = 1; req0_data = 8'h55;
        @(negedge clk);
        #1;
        chk("rst_tx_busy", tx_busy, 1);
        chk("rst_send_en", uart_send_en, 0);
        chk("rst_din", uart_din, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_overrun", rx_overrun, 0);

        // 1: lone CPU byte after reset release.
        do_reset();
        hi = 0;
        for (int i = 0; i < 230; i++) begin
            req0_valid = (acc_cyc.size() == 0);
            step();
            if (uart_send_en) hi++;
        end
        chk("t1_accepts", acc_cyc.size(), 1);
        if (acc_cyc.size() > 0) chk("t1_first_accept_cycle", acc_cyc[0], FC);
        chk("t1_send_en_cycles", hi, PC);
        chk("t1_din", uart_din, 8'h55);

        // 2: both requesters contend continuously.
        do_reset();
        req0_valid = 1; req0_data = 8'hA1; req1_valid = 1; req1_data = 8'hB2;
        for (int i = 0; i < 3 * (FC + 1) + FC + 5; i++) step();
        chk("t2_accepts", acc_cyc.size() >= 3, 1);
        if (acc_cyc.size() >= 3) begin
            chk("t2_grant1", acc_who[0], 0);
            chk("t2_grant2", acc_who[1], 1);
            chk("t2_grant3", acc_who[2], 0);
            chk("t2_gap12", acc_cyc[1] - acc_cyc[0], FC + 1);
            chk("t2_gap23", acc_cyc[2] - acc_cyc[1], FC + 1);
        end
        req0_valid = 0; req1_valid = 0;

        // 3: loopback of a debug byte; one done level must give exactly one capture.
        do_reset();
        req1_data = 8'h3C; lb_at = -1; rises = 0; prev_v = 0;
        for (int i = 0; i < 300; i++) begin
            req1_valid = (acc_cyc.size() == 0);
            if (lb_at < 0 && acc_cyc.size() > 0) lb_at = acc_cyc[0] + 10 * (CF / BPS);
            rx_done_i = (lb_at >= 0 && cyc >= lb_at && cyc < lb_at + 3);
            rx_byte_i = rx_done_i ? uart_din : 8'h00;
            step();
            if (rx_valid && !prev_v) rises++;
            prev_v = rx_valid;
        end
        chk("t3_rx_rises", rises, 1);
        chk("t3_rx_data", rx_data, 8'h3C);
        chk("t3_rx_valid", rx_valid, 1);
        rx_done_i = 0; req1_valid = 0;

        // 4/5: RX holding register table; expectations are the state after the edge.
        do_reset();
        vt = '{
            '{1, 8'h11, 0, 0, 1, 8'h11, 0}, '{1, 8'h11, 0, 0, 1, 8'h11, 0},
            '{0, 8'h00, 0, 0, 1, 8'h11, 0}, '{1, 8'h22, 0, 0, 1, 8'h11, 1},
            '{0, 8'h00, 0, 0, 1, 8'h11, 1}, '{1, 8'h33, 0, 1, 1, 8'h11, 1},
            '{0, 8'h00, 0, 1, 1, 8'h11, 0}, '{0, 8'h00, 1, 0, 0, 8'h11, 0},
            '{1, 8'h44, 0, 0, 1, 8'h44, 0}, '{0, 8'h00, 0, 0, 1, 8'h44, 0},
            '{1, 8'h55, 1, 0, 1, 8'h55, 0}, '{1, 8'h55, 1, 0, 0, 8'h55, 0},
            '{0, 8'h00, 1, 0, 0, 8'h55, 0}, '{1, 8'h66, 0, 0, 1, 8'h66, 0}
        };
        foreach (vt[k]) begin
            rx_done_i = vt[k].done; rx_byte_i = vt[k].byt;
            rx_ack = vt[k].ack; rx_overrun_clr = vt[k].clr;
            step();
            chk($sformatf("vec%0d_valid", k), rx_valid, vt[k].e_valid);
            chk($sformatf("vec%0d_data", k), rx_data, vt[k].e_data);
            chk($sformatf("vec%0d_overrun", k), rx_overrun, vt[k].e_ovr);
        end
        rx_done_i = 0; rx_ack = 0; rx_overrun_clr = 0;

        // 6: asynchronous reset in the middle of a send pulse.
        do_reset();
        req0_valid = 1; req0_data = 8'h5A;
        for (int i = 0; i < 200 && acc_cyc.size() == 0; i++) step();
        chk("t6_accepted", acc_cyc.size(), 1);
        step();
        step();
        chk("t6_pulse_before_rst", uart_send_en, 1);
        resetn = 0;
        #1;
        chk("t6_async_send_en", uart_send_en, 0);
        chk("t6_async_busy", tx_busy, 1);
        @(negedge clk);
        init_model();
        resetn = 1;
        for (int i = 0; i < FC + 5; i++) step();
        chk("t6_accepts", acc_cyc.size(), 1);
        if (acc_cyc.size() > 0) chk("t6_first_accept_cycle", acc_cyc[0], FC);

        // Random traffic on both sides against the model.
        do_reset();
        done_left = 0;
        for (int i = 0; i < 6000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            if (done_left > 0) begin
                rx_done_i = 1; done_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                rx_done_i = 1; done_left = $urandom_range(1, 4); rx_byte_i = 8'($urandom);
            end else begin
                rx_done_i = 0;
            end
            rx_ack = ($urandom_range(0, 7) == 0);
            rx_overrun_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        chk("rand_accepts_seen", acc_cyc.size() > 40, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
